int_issue_queue_ooo: RTL and testbench

Parametrised, registered, age-ordered integer issue queue with oldest-ready-first selection, multi-port CDB wakeup, valid/ready handshakes on both sides and pipeline flush. It sits between the dispatcher and the integer ALU and holds renamed instructions until both source operands are available. It then issues one instruction per cycle to the execution unit.

---
 rtl/int_iq_pkg.sv | 33 +++
 rtl/int_iq_oldest_select.sv | 29 ++
 rtl/int_issue_queue_ooo.sv | 175 +++++++++++++++++
 tb/tb_int_issue_queue_ooo.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/int_iq_pkg.sv
// Shared types and constants for the integer issue queue.
//   IQ_DATA_W / IQ_TAG_W : operand and physical-tag widths used by the entry
//                          record; the queue's DATA_W / TAG_W must match them.
//   alu_opcode_e         : integer ALU opcode encodings.
//   int_iq_entry_t       : one queue slot (valid, destination, opcode fields,
//                          two source operands with producer tag and ready bit).
package int_iq_pkg;

  localparam int unsigned IQ_DATA_W = 32;
  localparam int unsigned IQ_TAG_W  = 6;

  typedef enum logic [6:0] {
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111
  } alu_opcode_e;

  typedef struct packed {
    logic                 valid;
    logic [IQ_TAG_W-1:0]  rd_tag;
    logic [6:0]           opcode;
    logic [2:0]           func3;
    logic [6:0]           func7;
    logic [IQ_DATA_W-1:0] rs_data;
    logic [IQ_TAG_W-1:0]  rs_tag;
    logic                 rs_val;
    logic [IQ_DATA_W-1:0] rt_data;
    logic [IQ_TAG_W-1:0]  rt_tag;
    logic                 rt_val;
  } int_iq_entry_t;

endpackage

// File: rtl/int_iq_oldest_select.sv
// Priority encoder picking the oldest ready entry.
//   ready : per-entry ready flags, bit 0 is the oldest entry
//   found : at least one ready bit is set
//   idx   : lowest set index (0 when nothing is ready)
module int_iq_oldest_select
  import int_iq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic [DEPTH-1:0]         ready,
  output logic                     found,
  output logic [$clog2(DEPTH)-1:0] idx
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  // Scan from the top down so the lowest ready index is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = DEPTH; i > 0; i--) begin
      if (ready[i-1]) begin
        found = 1'b1;
        idx   = IDX_W'(i - 1);
      end
    end
  end

endmodule

// File: rtl/int_issue_queue_ooo.sv
// Age-ordered integer issue queue with oldest-ready-first selection.
// Holds renamed instructions until both source operands are available, wakes
// operands from NUM_CDB broadcast ports, and issues one instruction per cycle.
// Ports:
//   clk, reset (sync, active-low), flush
//   dispatch_*   : valid/ready input handshake carrying a renamed instruction
//   cdb_valid/tag/data : packed broadcast ports, port p at [p*W +: W]
//   issue_*      : valid/ready output handshake; data outputs are 0 when idle
//   occupancy    : number of valid entries
// DATA_W and TAG_W must equal the package widths IQ_DATA_W and IQ_TAG_W.
module int_issue_queue_ooo
  import int_iq_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned DATA_W  = IQ_DATA_W,
  parameter int unsigned TAG_W   = IQ_TAG_W,
  parameter int unsigned NUM_CDB = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       dispatch_valid,
  output logic                       dispatch_ready,
  input  logic [DATA_W-1:0]          dispatch_rs_data,
  input  logic [DATA_W-1:0]          dispatch_rt_data,
  input  logic [TAG_W-1:0]           dispatch_rs_tag,
  input  logic [TAG_W-1:0]           dispatch_rt_tag,
  input  logic                       dispatch_rs_val,
  input  logic                       dispatch_rt_val,
  input  logic [6:0]                 dispatch_opcode,
  input  logic [2:0]                 dispatch_func3,
  input  logic [6:0]                 dispatch_func7,
  input  logic [TAG_W-1:0]           dispatch_rd_tag,
  input  logic [NUM_CDB-1:0]         cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]   cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]  cdb_data,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [DATA_W-1:0]          issue_rs_data,
  output logic [DATA_W-1:0]          issue_rt_data,
  output logic [TAG_W-1:0]           issue_rd_tag,
  output logic [6:0]                 issue_opcode,
  output logic [2:0]                 issue_funct3,
  output logic [6:0]                 issue_funct7,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  int_iq_entry_t q       [DEPTH];
  int_iq_entry_t woken   [DEPTH];
  int_iq_entry_t shifted [DEPTH];
  int_iq_entry_t q_nxt   [DEPTH];
  int_iq_entry_t new_e;

  logic [CNT_W-1:0] count, count_nxt, ins_pos;
  logic [DEPTH-1:0] rdy;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             issue_fire, disp_fire;

  // Returns {val, data}; an operand already valid is never overwritten and
  // the lowest-numbered matching port supplies the data.
  function automatic logic [IQ_DATA_W:0] wake(
    input logic                      val,
    input logic [IQ_TAG_W-1:0]       tag,
    input logic [IQ_DATA_W-1:0]      data,
    input logic [NUM_CDB-1:0]        cv,
    input logic [NUM_CDB*TAG_W-1:0]  ct,
    input logic [NUM_CDB*DATA_W-1:0] cd
  );
    logic                 hit;
    logic [IQ_DATA_W-1:0] d;
    hit = val;
    d   = data;
    for (int unsigned p = 0; p < NUM_CDB; p++) begin
      if (!hit && cv[p] && (ct[p*TAG_W +: TAG_W] == tag)) begin
        hit = 1'b1;
        d   = cd[p*DATA_W +: DATA_W];
      end
    end
    return {hit, d};
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rdy[i] = q[i].valid && q[i].rs_val && q[i].rt_val;
    end
  end

  int_iq_oldest_select #(.DEPTH(DEPTH)) u_sel (
    .ready (rdy),
    .found (sel_found),
    .idx   (sel_idx)
  );

  assign dispatch_ready = (count < CNT_W'(DEPTH)) && reset && !flush;
  assign issue_valid    = sel_found && reset;
  assign issue_fire     = issue_valid && issue_ready;
  assign disp_fire      = dispatch_valid && dispatch_ready;
  assign occupancy      = reset ? count : '0;

  assign issue_rs_data = issue_valid ? q[sel_idx].rs_data : '0;
  assign issue_rt_data = issue_valid ? q[sel_idx].rt_data : '0;
  assign issue_rd_tag  = issue_valid ? q[sel_idx].rd_tag  : '0;
  assign issue_opcode  = issue_valid ? q[sel_idx].opcode  : '0;
  assign issue_funct3  = issue_valid ? q[sel_idx].func3   : '0;
  assign issue_funct7  = issue_valid ? q[sel_idx].func7   : '0;

  // Wakeup is computed on the current slots first, then the collapse moves
  // the woken copy, so an entry shifting down keeps a capture from this cycle.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      woken[i] = q[i];
      if (q[i].valid) begin
        {woken[i].rs_val, woken[i].rs_data} =
          wake(q[i].rs_val, q[i].rs_tag, q[i].rs_data, cdb_valid, cdb_tag, cdb_data);
        {woken[i].rt_val, woken[i].rt_data} =
          wake(q[i].rt_val, q[i].rt_tag, q[i].rt_data, cdb_valid, cdb_tag, cdb_data);
      end
    end

    for (int unsigned i = 0; i < DEPTH - 1; i++) begin
      shifted[i] = woken[i+1];
    end
    shifted[DEPTH-1] = '0;

    new_e        = '0;
    new_e.valid  = 1'b1;
    new_e.rd_tag = dispatch_rd_tag;
    new_e.opcode = dispatch_opcode;
    new_e.func3  = dispatch_func3;
    new_e.func7  = dispatch_func7;
    new_e.rs_tag = dispatch_rs_tag;
    new_e.rt_tag = dispatch_rt_tag;
    {new_e.rs_val, new_e.rs_data} =
      wake(dispatch_rs_val, dispatch_rs_tag, dispatch_rs_data, cdb_valid, cdb_tag, cdb_data);
    {new_e.rt_val, new_e.rt_data} =
      wake(dispatch_rt_val, dispatch_rt_tag, dispatch_rt_data, cdb_valid, cdb_tag, cdb_data);

    ins_pos = issue_fire ? (count - CNT_W'(1)) : count;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      q_nxt[i] = woken[i];
      if (issue_fire && (i >= 32'(sel_idx))) begin
        q_nxt[i] = shifted[i];
      end
      if (disp_fire && (i == 32'(ins_pos))) begin
        q_nxt[i] = new_e;
      end
    end

    case ({disp_fire, issue_fire})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
    end else begin
      count <= count_nxt;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q[i] <= q_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_int_issue_queue_ooo.sv
// Directed, table-driven bench for int_issue_queue_ooo: each record is one
// cycle of stimulus plus the outputs expected just before that cycle's edge.
module tb_int_issue_queue_ooo;
  import int_iq_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, dispatch_valid, dispatch_ready;
  logic [31:0] dispatch_rs_data, dispatch_rt_data;
  logic [5:0]  dispatch_rs_tag, dispatch_rt_tag, dispatch_rd_tag;
  logic        dispatch_rs_val, dispatch_rt_val;
  logic [6:0]  dispatch_opcode, dispatch_func7;
  logic [2:0]  dispatch_func3;
  logic [1:0]  cdb_valid;
  logic [11:0] cdb_tag;
  logic [63:0] cdb_data;
  logic        issue_valid, issue_ready;
  logic [31:0] issue_rs_data, issue_rt_data;
  logic [5:0]  issue_rd_tag;
  logic [6:0]  issue_opcode, issue_funct7;
  logic [2:0]  issue_funct3;
  logic [2:0]  occupancy;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  int_issue_queue_ooo #(.DEPTH(4), .DATA_W(32), .TAG_W(6), .NUM_CDB(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_rs_data(dispatch_rs_data), .dispatch_rt_data(dispatch_rt_data),
    .dispatch_rs_tag(dispatch_rs_tag), .dispatch_rt_tag(dispatch_rt_tag),
    .dispatch_rs_val(dispatch_rs_val), .dispatch_rt_val(dispatch_rt_val),
    .dispatch_opcode(dispatch_opcode), .dispatch_func3(dispatch_func3),
    .dispatch_func7(dispatch_func7), .dispatch_rd_tag(dispatch_rd_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs_data(issue_rs_data), .issue_rt_data(issue_rt_data),
    .issue_rd_tag(issue_rd_tag), .issue_opcode(issue_opcode),
    .issue_funct3(issue_funct3), .issue_funct7(issue_funct7),
    .occupancy(occupancy)
  );

  typedef struct {
    logic        rst, fl, dv;
    logic [5:0]  rd, rs_tag, rt_tag;
    logic        rs_val, rt_val;
    logic [1:0]  cv;
    logic [5:0]  ct0, ct1;
    logic [31:0] cd0, cd1;
    logic        ir;
    logic        e_dr, e_iv;
    logic [5:0]  e_rd;
    logic [31:0] e_rs, e_rt;
    logic [2:0]  e_occ;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic rst, fl, dv, input int rd, rs_tag,
                              input logic rs_val, input int rt_tag, input logic rt_val,
                              input logic ir, e_dr, e_iv, input int e_rd,
                              input logic [31:0] e_rs, e_rt, input int e_occ);
    vec_t v;
    v.rst = rst; v.fl = fl; v.dv = dv; v.rd = 6'(rd);
    v.rs_tag = 6'(rs_tag); v.rs_val = rs_val;
    v.rt_tag = 6'(rt_tag); v.rt_val = rt_val;
    v.cv = 2'b00; v.ct0 = '0; v.ct1 = '0; v.cd0 = '0; v.cd1 = '0;
    v.ir = ir; v.e_dr = e_dr; v.e_iv = e_iv; v.e_rd = 6'(e_rd);
    v.e_rs = e_rs; v.e_rt = e_rt; v.e_occ = 3'(e_occ);
    return v;
  endfunction

  function automatic vec_t cdb(input vec_t vi, input logic [1:0] cv,
                               input int t0, input logic [31:0] d0,
                               input int t1, input logic [31:0] d1);
    vec_t v;
    v = vi;
    v.cv = cv; v.ct0 = 6'(t0); v.cd0 = d0; v.ct1 = 6'(t1); v.cd1 = d1;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    logic [6:0] e_opc;
    @(negedge clk);
    reset            = v.rst;
    flush            = v.fl;
    dispatch_valid   = v.dv;
    dispatch_rd_tag  = v.rd;
    dispatch_rs_tag  = v.rs_tag;
    dispatch_rs_val  = v.rs_val;
    dispatch_rt_tag  = v.rt_tag;
    dispatch_rt_val  = v.rt_val;
    dispatch_rs_data = 32'h100 + 32'(v.rd);
    dispatch_rt_data = 32'h200 + 32'(v.rd);
    dispatch_opcode  = OPC_OP;
    dispatch_func3   = v.rd[2:0];
    dispatch_func7   = 7'h20;
    cdb_valid        = v.cv;
    cdb_tag          = {v.ct1, v.ct0};
    cdb_data         = {v.cd1, v.cd0};
    issue_ready      = v.ir;
    #1;
    e_opc = v.e_iv ? OPC_OP : 7'h00;
    check({nm, ".dispatch_ready"}, 32'(dispatch_ready), 32'(v.e_dr));
    check({nm, ".issue_valid"},    32'(issue_valid),    32'(v.e_iv));
    check({nm, ".issue_rd_tag"},   32'(issue_rd_tag),   32'(v.e_rd));
    check({nm, ".issue_rs_data"},  issue_rs_data,       v.e_rs);
    check({nm, ".issue_rt_data"},  issue_rt_data,       v.e_rt);
    check({nm, ".occupancy"},      32'(occupancy),      32'(v.e_occ));
    check({nm, ".issue_opcode"},   32'(issue_opcode),   32'(e_opc));
    check({nm, ".issue_funct3"},   32'(issue_funct3),   32'(v.e_rd[2:0]));
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; dispatch_valid = 1'b0; issue_ready = 1'b0;
    dispatch_rs_data = '0; dispatch_rt_data = '0; dispatch_rs_tag = '0;
    dispatch_rt_tag = '0; dispatch_rs_val = 1'b0; dispatch_rt_val = 1'b0;
    dispatch_opcode = '0; dispatch_func3 = '0; dispatch_func7 = '0;
    dispatch_rd_tag = '0; cdb_valid = '0; cdb_tag = '0; cdb_data = '0;

    // rst fl dv rd rs_tag rs_v rt_tag rt_v ir | dr iv rd rs rt occ
    // reset hold with dispatch offered
    repeat (3) tv.push_back(mk(0,0,1, 1, 0,1, 0,1, 0,  0,0, 0, 0, 0, 0));
    // fill with rd_tag 1..4, fifth refused
    tv.push_back(mk(1,0,1, 1, 0,1, 0,1, 0,  1,0, 0, 0, 0, 0));
    tv.push_back(mk(1,0,1, 2, 0,1, 0,1, 0,  1,1, 1, 'h101, 'h201, 1));
    tv.push_back(mk(1,0,1, 3, 0,1, 0,1, 0,  1,1, 1, 'h101, 'h201, 2));
    tv.push_back(mk(1,0,1, 4, 0,1, 0,1, 0,  1,1, 1, 'h101, 'h201, 3));
    tv.push_back(mk(1,0,1, 5, 0,1, 0,1, 0,  0,1, 1, 'h101, 'h201, 4));
    // drain; full queue refuses rd 5 even while issuing
    tv.push_back(mk(1,0,1, 5, 0,1, 0,1, 1,  0,1, 1, 'h101, 'h201, 4));
    tv.push_back(mk(1,0,0, 0, 0,1, 0,1, 1,  1,1, 2, 'h102, 'h202, 3));
    tv.push_back(mk(1,0,0, 0, 0,1, 0,1, 1,  1,1, 3, 'h103, 'h203, 2));
    tv.push_back(mk(1,0,0, 0, 0,1, 0,1, 1,  1,1, 4, 'h104, 'h204, 1));
    // out-of-order: rd 6 waits on tag 9, rd 7 ready
    tv.push_back(mk(1,0,1, 6, 9,0, 0,1, 1,  1,0, 0, 0, 0, 0));
    tv.push_back(mk(1,0,1, 7, 0,1, 0,1, 1,  1,0, 0, 0, 0, 1));
    tv.push_back(cdb(mk(1,0,0, 0, 0,1, 0,1, 1,  1,1, 7, 'h107, 'h207, 2),
                     2'b11, 3, 32'h1111, 9, 32'hDEAD));
    tv.push_back(mk(1,0,0, 0, 0,1, 0,1, 1,  1,1, 6, 'hDEAD, 'h206, 1));
    // dispatch-time wakeup, both ports match, port 0 wins
    tv.push_back(cdb(mk(1,0,1, 8, 0,1, 12,0, 1,  1,0, 0, 0, 0, 0),
                     2'b11, 12, 32'h55, 12, 32'h77));
    tv.push_back(mk(1,0,0, 0, 0,1, 0,1, 1,  1,1, 8, 'h108, 'h55, 1));
    // simultaneous dispatch and issue at occupancy 3
    tv.push_back(mk(1,0,1, 9, 0,1, 0,1, 0,  1,0, 0, 0, 0, 0));
    tv.push_back(mk(1,0,1,10, 0,1, 0,1, 0,  1,1, 9, 'h109, 'h209, 1));
    tv.push_back(mk(1,0,1,11, 0,1, 0,1, 0,  1,1, 9, 'h109, 'h209, 2));
    tv.push_back(mk(1,0,1,12, 0,1, 0,1, 1,  1,1, 9, 'h109, 'h209, 3));
    tv.push_back(mk(1,0,0, 0, 0,1, 0,1, 0,  1,1,10, 'h10A, 'h20A, 3));
    tv.push_back(mk(1,0,0, 0, 0,1, 0,1, 1,  1,1,10, 'h10A, 'h20A, 3));
    tv.push_back(mk(1,0,0, 0, 0,1, 0,1, 1,  1,1,11, 'h10B, 'h20B, 2));
    tv.push_back(mk(1,0,0, 0, 0,1, 0,1, 1,  1,1,12, 'h10C, 'h20C, 1));
    // wakeup of an entry that shifts down in the same cycle
    tv.push_back(mk(1,0,1,13, 0,1, 0,1, 1,  1,0, 0, 0, 0, 0));
    tv.push_back(mk(1,0,1,14,20,0, 0,1, 0,  1,1,13, 'h10D, 'h20D, 1));
    tv.push_back(cdb(mk(1,0,0, 0, 0,1, 0,1, 1,  1,1,13, 'h10D, 'h20D, 2),
                     2'b01, 20, 32'hBEEF, 0, 32'h0));
    tv.push_back(mk(1,0,1,15, 0,1, 0,1, 0,  1,1,14, 'hBEEF, 'h20E, 1));
    tv.push_back(mk(1,0,1,16, 0,1, 0,1, 0,  1,1,14, 'hBEEF, 'h20E, 2));
    // flush with 3 entries while dispatch is offered
    tv.push_back(mk(1,1,1,17, 0,1, 0,1, 0,  0,1,14, 'hBEEF, 'h20E, 3));
    tv.push_back(mk(1,0,0, 0, 0,1, 0,1, 0,  1,0, 0, 0, 0, 0));

    foreach (tv[i]) run_vec(tv[i], $sformatf("v%0d", i));

    // Full of non-ready entries: stall, ignore a tag differing only in the
    // MSB, then wake all at once and drain in age order.
    for (int k = 0; k < 4; k++)
      run_vec(mk(1,0,1, 20+k, 'h3E,0, 0,1, 0,  1,0, 0, 0, 0, k), $sformatf("fill%0d", k));
    for (int k = 0; k < 4; k++)
      run_vec(cdb(mk(1,0,0, 0, 0,1, 0,1, 1,  0,0, 0, 0, 0, 4), 2'b01, 'h1E, 32'h999, 0, 32'h0),
              $sformatf("stall%0d", k));
    run_vec(cdb(mk(1,0,0, 0, 0,1, 0,1, 1,  0,0, 0, 0, 0, 4), 2'b10, 0, 32'h0, 'h3E, 32'hABC),
            "wake_all");
    for (int k = 0; k < 4; k++)
      run_vec(mk(1,0,0, 0, 0,1, 0,1, 1,  (k > 0),1, 20+k, 32'hABC, 32'h214 + 32'(k), 4-k),
              $sformatf("drain%0d", k));
    run_vec(mk(1,0,0, 0, 0,1, 0,1, 1,  1,0, 0, 0, 0, 0), "empty");

    @(negedge clk);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
